// File: rtl/serial_div.sv
// Restoring serial divider: one quotient bit per clock, MSB first.
// Handshake is start/busy/done; a zero divisor skips the iterations.
module serial_div #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   dvd_r;
  logic [N-1:0]   dvs_r;
  logic [N-1:0]   sh_r;
  logic [N-1:0]   p_r;
  logic [N-1:0]   quo_r;

  logic [N:0]     p_shift;
  logic [N:0]     trial;
  logic [N:0]     p_next;
  logic           q_bit;

  // The stored partial remainder is always below the divisor, so N bits suffice;
  // the extra bit only exists in the shifted/trial values.
  always_comb begin
    p_shift = {p_r, sh_r[N-1]};
    trial   = p_shift - {1'b0, dvs_r};
    q_bit   = ~trial[N];
    p_next  = q_bit ? trial : p_shift;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      dvd_r       <= '0;
      dvs_r       <= '0;
      sh_r        <= '0;
      p_r         <= '0;
      quo_r       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dvd_r <= dividend;
            dvs_r <= divisor;
            sh_r  <= dividend;
            p_r   <= '0;
            quo_r <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= (divisor == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          p_r   <= p_next[N-1:0];
          sh_r  <= {sh_r[N-2:0], 1'b0};
          quo_r <= {quo_r[N-2:0], q_bit};
          if (cnt == CW'(N - 1)) begin
            state       <= DONE;
            done        <= 1'b1;
            quotient    <= {quo_r[N-2:0], q_bit};
            remainder   <= p_next[N-1:0];
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          // A zero divisor enters DONE with done low and publishes one edge later.
          if (!done) begin
            done        <= 1'b1;
            quotient    <= '1;
            remainder   <= dvd_r;
            div_by_zero <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_div.md
SERIAL_DIV -- requirements
Module: serial_div

Interface
REQ-001 The block SHALL have parameter N, default 8, meaning operand, quotient and remainder width in bits (N >= 2).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend  input  N  unsigned dividend; sampled with start.
REQ-006 The block SHALL have port divisor  input  N  unsigned divisor; sampled with start.
REQ-007 The block SHALL have port busy  output  1  high from the accepting edge until the edge that returns the block to IDLE.
REQ-008 The block SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 The block SHALL have port quotient  output  N  registered quotient.
REQ-010 The block SHALL have port remainder  output  N  registered remainder.
REQ-011 The block SHALL have port div_by_zero  output  1  registered; set when the last accepted divisor was 0.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1: operands latched, iteration counter cleared, busy=1; next state RUN, or DONE if divisor==0.
REQ-014 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change while busy.
REQ-015 Algorithm SHALL be restoring, MSB first, one quotient bit per clock.
REQ-016 Each RUN cycle: partial remainder P (N+1 bits) = {P[N-1:0], next dividend bit}, then trial P - divisor computed N+1 bits wide.
REQ-017 If the trial result's MSB is 0, P SHALL take the trial result and the quotient bit SHALL be 1; otherwise P SHALL be restored and the quotient bit SHALL be 0.
REQ-018 RUN SHALL last exactly N cycles; the counter SHALL be ceil(log2(N+1)) bits wide and SHALL NOT wrap.
REQ-019 done SHALL rise on the Nth rising edge after the edge that accepted start (divide-by-zero case: the first edge after) and SHALL stay high for exactly one cycle.
REQ-020 On the edge entering DONE, quotient, remainder and div_by_zero SHALL update together; they SHALL hold until the next result.
REQ-021 divisor==0: quotient SHALL be all ones, remainder SHALL be the dividend, and div_by_zero SHALL be 1.
REQ-022 Valid division SHALL give div_by_zero=0, dividend == quotient*divisor + remainder, and remainder < divisor.
REQ-023 DONE SHALL return to IDLE on the next edge (busy=0 there); start in the DONE cycle SHALL be ignored.
REQ-024 Minimum spacing between accepted starts SHALL be N+2 cycles (3 for divide-by-zero).

Reset
REQ-025 While rst_n=0, state SHALL be IDLE; busy, done, quotient, remainder, div_by_zero and all internal registers SHALL be 0, irrespective of clk.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-028 Case N=8, 100/7, start at edge E0 -> done high after E8 only; quotient=14, remainder=2, div_by_zero=0; busy high E0..E9.
REQ-029 Case N=8, 37/0 -> done after E1; quotient=0xFF, remainder=37, div_by_zero=1; busy low after E2.
REQ-030 Boundary operands, N=8: 5/9 -> q=0, r=5; 255/1 -> q=255, r=0; 255/255 -> q=1, r=0; 0/3 -> q=0, r=0.
REQ-031 Case 200/3, start held high plus a new dividend/divisor applied during RUN and during the DONE cycle -> a single done; q=66, r=2; operands accepted only in the following IDLE.
REQ-032 rst_n pulsed low mid-RUN (after E4 of 100/7), asynchronous to clk -> all outputs 0 at once, no done pulse; next 100/7 -> q=14, r=2.
REQ-033 Randomized check, N=8, 1000 operand pairs including divisor 0: every result satisfies REQ-021/REQ-022, and the done timing of REQ-019 holds.
